comparator_arbiter: RTL and testbench
=====================================

# comparator_arbiter

Shares one 20-bit magnitude comparator between two requesters. Arbitration is round-robin, with an optional fixed-priority mode. Each granted request is latched, compared on the shared comparator, and the registered Lt/Gt/Eq flags are returned to that requester only. The block sits between client logic and the comparator, so the design needs a single comparator instance instead of one per client.

## Interface
Parameters:
- WIDTH, 20, operand width. Only 20 is supported because of the shared comparator instance.
- RR_ENABLE, 1, selects the arbitration mode.
  - 1: round-robin.
  - 0: fixed priority, requester 0 always wins.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next clk edge.
- req0_valid  in  1  requester 0 has an operand pair pending.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_ready  out  1  requester 0 accepted this cycle; combinational.
- req1_valid, req1_a, req1_b, req1_ready  same as above, for requester 1.
- rsp0_valid  out  1  one-cycle pulse: result for requester 0.
- rsp1_valid  out  1  one-cycle pulse: result for requester 1.
- rsp_lt, rsp_gt, rsp_eq  out  1 each  registered result flags, shared by both requesters; meaningful only while a rspN_valid is high.
- busy  out  1  high in COMPARE and RESPOND.

## Operation
- FSM states: IDLE -> COMPARE -> RESPOND -> IDLE.
- IDLE:
  - If no request is valid, stay in IDLE.
  - Otherwise compute the grant combinationally:
    - Only one valid: grant that requester.
    - Both valid: grant the requester named by prio_ptr (RR_ENABLE=1), or requester 0 (RR_ENABLE=0).
  - Assert reqN_ready for the granted requester only.
  - On the clock edge, latch a/b and the grant id, then go to COMPARE.
- COMPARE:
  - Drive the latched operands into the comparator.
  - Register its lt/gt/eq into rsp_lt/gt/eq.
  - Go to RESPOND.
- RESPOND:
  - Pulse rspN_valid for the latched grant id.
  - Set prio_ptr to the other requester.
  - Go to IDLE.
- Handshake rules:
  - A transfer happens when valid && ready are both high at a rising edge.
  - The requester holds valid and operands stable until ready.
  - ready is never asserted outside IDLE.
  - A requester that deasserts valid before it is granted loses nothing; no transaction occurs.
- Comparison is unsigned: exactly one of lt/gt/eq is 1 in every response.
- Responses have no backpressure; the requester must consume the pulse.

## Timing
- Reset values:
  - state = IDLE, prio_ptr = 0.
  - req0_ready = req1_ready = 0 during reset.
  - rsp0_valid = rsp1_valid = 0.
  - rsp_lt = rsp_gt = rsp_eq = 0, busy = 0.
- Latency: a handshake at edge T produces rspN_valid high during the cycle after edge T+2.
- Throughput: one comparison per 3 cycles.
- Back-to-back requests: the next grant can occur in the IDLE cycle right after RESPOND.
- Simultaneous requests, both valid continuously:
  - Grants alternate 0,1,0,1 in round-robin mode.
  - Only requester 0 is served in fixed-priority mode (starvation of requester 1 is accepted).
- Reset asserted in COMPARE or RESPOND: the in-flight transaction is dropped with no rsp pulse, and prio_ptr returns to 0.
- Reset and valid in the same cycle: reset wins and no handshake occurs.
- Boundary operands: 0 vs 0, 0 vs 20'hFFFFF and 20'hFFFFF vs 20'hFFFFF must produce correct flags.

## Structure
- Shared header cmp_defs.vh holds:
  - State encodings: S_IDLE=2'd0, S_COMPARE=2'd1, S_RESPOND=2'd2.
  - The default operand width, 20.
- One sub-module: the team's TwentyBitComparator, instantiated unchanged as the shared resource.
- The arbiter itself contains only:
  - the FSM,
  - the grant logic,
  - the operand/grant latch,
  - the result register.

## Test plan
- Reset, then req0 with a=20'h00001, b=20'h00000.
  - Expect: req0_ready=1 in the same cycle.
  - Expect: rsp0_valid pulse 3 cycles later with gt=1, lt=0, eq=0; rsp1_valid stays 0.
- req1 only, a=20'h00000, b=20'h7FFFF.
  - Expect: lt=1 on rsp1_valid; busy high for exactly 2 cycles.
- Both requesters valid for 4 grants, RR_ENABLE=1, req0 a=b=20'h12345, req1 a=20'hFFFFF b=20'h0.
  - Expect: grant order 0,1,0,1.
  - Expect: eq=1 on rsp0_valid, gt=1 on rsp1_valid.
- Same stimulus with RR_ENABLE=0.
  - Expect: only req0 is granted; req1_ready stays 0.
- Reset asserted in the COMPARE cycle of a req1 transaction.
  - Expect: no rsp1_valid; outputs return to reset values.
  - Expect: a following simultaneous request is granted to requester 0.
- req0_valid pulsed while busy, then dropped before IDLE.
  - Expect: no req0_ready and no extra response.

Source files
------------

// File: rtl/comparator_arbiter_pkg.sv
// Shared types for the two-client comparator arbiter: FSM states, operand latch, result flags.
// Pure declarations; no timing or flow-control behaviour of its own.
// Grant helper is combinational and carries no backpressure.
package comparator_arbiter_pkg;

   localparam int CMP_WIDTH = 20;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPARE = 2'd1,
      S_RESPOND = 2'd2
   } state_t;

   typedef struct packed {
      logic [CMP_WIDTH-1:0] a;
      logic [CMP_WIDTH-1:0] b;
      logic                 gid;
   } op_latch_t;

   typedef struct packed {
      logic lt;
      logic gt;
      logic eq;
   } cmp_flags_t;

   // Returns the requester id to serve; only meaningful when v0 or v1 is set.
   function automatic logic pick_grant(input logic v0, input logic v1,
                                       input logic ptr, input logic rr_en);
      if (v0 && v1) begin
         return rr_en ? ptr : 1'b0;
      end
      return v1;
   endfunction

endpackage

// File: rtl/comparator_arbiter_cmp.sv
// Shared 20-bit unsigned magnitude comparator; exactly one of lt/gt/eq is high.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the owner registers the flags.
module comparator_arbiter_cmp
   import comparator_arbiter_pkg::*;
(
   input  logic [CMP_WIDTH-1:0] a,
   input  logic [CMP_WIDTH-1:0] b,
   output logic                 lt,
   output logic                 gt,
   output logic                 eq
);

   assign lt = (a <  b);
   assign gt = (a >  b);
   assign eq = (a == b);

endmodule

// File: rtl/comparator_arbiter.sv
// Arbitrates two requesters onto one shared comparator and returns registered flags to the winner.
// Latency: handshake at edge T gives a one-cycle rspN_valid pulse after edge T+2; one compare per 3 cycles.
// Backpressure: readyN only in IDLE for the granted requester; responses cannot be stalled.
module comparator_arbiter
   import comparator_arbiter_pkg::*;
#(
   parameter int WIDTH     = CMP_WIDTH,
   parameter bit RR_ENABLE = 1'b1
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             rsp0_valid,
   output logic             rsp1_valid,
   output logic             rsp_lt,
   output logic             rsp_gt,
   output logic             rsp_eq,
   output logic             busy
);

   state_t     state_q;
   state_t     state_d;
   logic       prio_ptr_q;
   op_latch_t  op_q;
   cmp_flags_t flags_q;
   cmp_flags_t cmp_res;
   logic [1:0] rsp_vld_q;
   logic       grant;
   logic       take;

   comparator_arbiter_cmp u_cmp (
      .a  (op_q.a),
      .b  (op_q.b),
      .lt (cmp_res.lt),
      .gt (cmp_res.gt),
      .eq (cmp_res.eq)
   );

   // Reset gates ready combinationally so a valid seen during reset never handshakes.
   always_comb begin
      state_d    = state_q;
      grant      = 1'b0;
      take       = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!reset && (req0_valid || req1_valid)) begin
               grant      = pick_grant(req0_valid, req1_valid, prio_ptr_q, RR_ENABLE);
               take       = 1'b1;
               req0_ready = ~grant;
               req1_ready = grant;
               state_d    = S_COMPARE;
            end
         end
         S_COMPARE: state_d = S_RESPOND;
         S_RESPOND: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         prio_ptr_q <= 1'b0;
         op_q       <= '0;
         flags_q    <= '0;
         rsp_vld_q  <= '0;
      end else begin
         state_q   <= state_d;
         rsp_vld_q <= '0;
         if (take) begin
            op_q.a   <= grant ? req1_a : req0_a;
            op_q.b   <= grant ? req1_b : req0_b;
            op_q.gid <= grant;
         end
         if (state_q == S_COMPARE) begin
            flags_q <= cmp_res;
         end
         // The pulse lands in the cycle after RESPOND, where the flags are already stable.
         if (state_q == S_RESPOND) begin
            rsp_vld_q[op_q.gid] <= 1'b1;
            prio_ptr_q          <= ~op_q.gid;
         end
      end
   end

   assign rsp0_valid = rsp_vld_q[0];
   assign rsp1_valid = rsp_vld_q[1];
   assign rsp_lt     = flags_q.lt;
   assign rsp_gt     = flags_q.gt;
   assign rsp_eq     = flags_q.eq;
   assign busy       = (state_q == S_COMPARE) || (state_q == S_RESPOND);

endmodule

// File: tb/tb_comparator_arbiter.sv
// Bench for comparator_arbiter: round-robin instance (index 0) and fixed-priority instance (index 1).
// Expected responses are queued at handshake time and matched against rsp pulses.
module tb_comparator_arbiter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // [dut][requester]
   logic [1:0][1:0]       v;
   logic [1:0][1:0][19:0] a;
   logic [1:0][1:0][19:0] b;
   logic [1:0][1:0]       rdy;
   logic [1:0][1:0]       rspv;
   logic [1:0]            lt, gt, eq, busy;

   comparator_arbiter #(.WIDTH(20), .RR_ENABLE(1'b1)) u_rr (
      .clk(clk), .reset(reset),
      .req0_valid(v[0][0]), .req0_a(a[0][0]), .req0_b(b[0][0]), .req0_ready(rdy[0][0]),
      .req1_valid(v[0][1]), .req1_a(a[0][1]), .req1_b(b[0][1]), .req1_ready(rdy[0][1]),
      .rsp0_valid(rspv[0][0]), .rsp1_valid(rspv[0][1]),
      .rsp_lt(lt[0]), .rsp_gt(gt[0]), .rsp_eq(eq[0]), .busy(busy[0])
   );

   comparator_arbiter #(.WIDTH(20), .RR_ENABLE(1'b0)) u_fp (
      .clk(clk), .reset(reset),
      .req0_valid(v[1][0]), .req0_a(a[1][0]), .req0_b(b[1][0]), .req0_ready(rdy[1][0]),
      .req1_valid(v[1][1]), .req1_a(a[1][1]), .req1_b(b[1][1]), .req1_ready(rdy[1][1]),
      .rsp0_valid(rspv[1][0]), .rsp1_valid(rspv[1][1]),
      .rsp_lt(lt[1]), .rsp_gt(gt[1]), .rsp_eq(eq[1]), .busy(busy[1])
   );

   typedef struct {
      int         id;
      logic [2:0] f;
      int         cyc;
   } exp_t;

   exp_t q_rr[$];
   exp_t q_fp[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [2:0] ref_flags(input logic [19:0] x, input logic [19:0] y);
      return {x < y, x > y, x == y};
   endfunction

   task automatic push_exp(input int d, input int id, input logic [19:0] x, input logic [19:0] y);
      exp_t e;
      e.id  = id;
      e.f   = ref_flags(x, y);
      e.cyc = cyc + 1;
      if (d == 0) q_rr.push_back(e);
      else        q_fp.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      logic have;
      for (int d = 0; d < 2; d++) begin
         if (rspv[d] != 2'b00) begin
            have = 1'b0;
            if (d == 0 && q_rr.size() > 0) begin
               e = q_rr.pop_front(); have = 1'b1;
            end else if (d == 1 && q_fp.size() > 0) begin
               e = q_fp.pop_front(); have = 1'b1;
            end
            if (!have) begin
               check_eq("rsp_unexpected", {30'd0, rspv[d]}, 32'd0);
            end else begin
               check_eq("rsp_id", {30'd0, rspv[d]}, (e.id != 0) ? 32'd2 : 32'd1);
               check_eq("rsp_flags", {29'd0, lt[d], gt[d], eq[d]}, {29'd0, e.f});
               check_eq("rsp_latency", cyc, e.cyc + 2);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the handshake edge with valid dropped.
   task automatic send_one(input int d, input int id, input logic [19:0] x, input logic [19:0] y,
                           input bit keep, output int n);
      n = 0;
      v[d][id] = 1'b1; a[d][id] = x; b[d][id] = y;
      #1;
      while (!rdy[d][id] && n < 40) begin
         @(negedge clk); #1; n++;
      end
      check_eq("send_rdy", {31'd0, rdy[d][id]}, 32'd1);
      if (rdy[d][id] && keep) push_exp(d, id, x, y);
      @(negedge clk);
      v[d][id] = 1'b0;
   endtask

   task automatic run_both(input int d, output logic [3:0] order, output int ng,
                           output logic both_seen, output logic r1_seen);
      ng = 0; order = '0; both_seen = 1'b0; r1_seen = 1'b0;
      a[d][0] = 20'h12345; b[d][0] = 20'h12345;
      a[d][1] = 20'hFFFFF; b[d][1] = 20'h00000;
      v[d] = 2'b11;
      for (int c = 0; c < 60 && ng < 4; c++) begin
         #1;
         if (rdy[d] == 2'b11) both_seen = 1'b1;
         if (rdy[d][1]) r1_seen = 1'b1;
         if (rdy[d] != 2'b00) begin
            order[ng] = rdy[d][1];
            push_exp(d, rdy[d][1] ? 1 : 0, a[d][rdy[d][1]], b[d][rdy[d][1]]);
            ng++;
         end
         @(negedge clk);
      end
      v[d] = 2'b00;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && (q_rr.size() + q_fp.size()) > 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check_eq(tag, q_rr.size() + q_fp.size(), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_rdy"}, {28'd0, rdy[1], rdy[0]}, 32'd0);
      check_eq({tag, "_rsp"}, {28'd0, rspv[1], rspv[0]}, 32'd0);
      check_eq({tag, "_flags"}, {26'd0, lt, gt, eq}, 32'd0);
      check_eq({tag, "_busy"}, {30'd0, busy}, 32'd0);
   endtask

   initial begin : global_timeout
      #200000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int         nw;
      int         bc;
      int         ng;
      logic [3:0] order;
      logic       both_seen;
      logic       r1_seen;
      logic [19:0] bnd_a [4];
      logic [19:0] bnd_b [4];
      bnd_a = '{20'h00000, 20'h00000, 20'hFFFFF, 20'hFFFFF};
      bnd_b = '{20'h00000, 20'hFFFFF, 20'hFFFFF, 20'h00000};

      reset = 1'b1; v = '0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      // valid during reset must not handshake
      v[0][0] = 1'b1; v[1][1] = 1'b1;
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      v = '0; reset = 1'b0;

      // req0 only: gt, ready in the same cycle
      send_one(0, 0, 20'h00001, 20'h00000, 1'b1, nw);
      check_eq("t1_rdy_same_cycle", nw, 32'd0);
      drain("t1_drain");

      // req1 only: lt, busy for two cycles
      send_one(0, 1, 20'h00000, 20'h7FFFF, 1'b1, nw);
      bc = 0;
      for (int i = 0; i < 5; i++) begin
         if (busy[0]) bc++;
         @(negedge clk);
      end
      check_eq("t2_busy_cycles", bc, 32'd2);
      drain("t2_drain");

      // boundary operands, alternating requesters
      for (int i = 0; i < 4; i++) send_one(0, i % 2, bnd_a[i], bnd_b[i], 1'b1, nw);
      drain("bnd_drain");

      // round-robin with both requesters held valid
      reset = 1'b1; @(negedge clk); reset = 1'b0;
      run_both(0, order, ng, both_seen, r1_seen);
      check_eq("rr_grants", ng, 32'd4);
      check_eq("rr_order", {28'd0, order}, 32'hA);
      check_eq("rr_one_hot_rdy", {31'd0, both_seen}, 32'd0);
      drain("rr_drain");

      // fixed priority: requester 1 starves
      run_both(1, order, ng, both_seen, r1_seen);
      check_eq("fp_grants", ng, 32'd4);
      check_eq("fp_order", {28'd0, order}, 32'd0);
      check_eq("fp_rdy1_seen", {31'd0, r1_seen}, 32'd0);
      drain("fp_drain");

      // reset during COMPARE of a req1 transaction; prio_ptr points at 1 beforehand
      send_one(0, 0, 20'h00003, 20'h00003, 1'b1, nw);
      send_one(0, 1, 20'h00005, 20'h00004, 1'b0, nw);
      check_eq("t5_in_compare", {31'd0, busy[0]}, 32'd1);
      reset = 1'b1;
      @(negedge clk); #1;
      check_reset_outputs("t5_reset");
      reset = 1'b0;
      a[0][0] = 20'h00007; b[0][0] = 20'h00009;
      a[0][1] = 20'h00009; b[0][1] = 20'h00007;
      v[0] = 2'b11;
      #1;
      check_eq("t5_grant_after_rst", {30'd0, rdy[0]}, 32'd1);
      if (rdy[0] == 2'b01) push_exp(0, 0, a[0][0], b[0][0]);
      @(negedge clk);
      v[0] = 2'b00;
      drain("t5_drain");

      // req0 pulsed while busy and withdrawn before IDLE
      send_one(0, 1, 20'h00010, 20'h00020, 1'b1, nw);
      v[0][0] = 1'b1; a[0][0] = 20'h00055; b[0][0] = 20'h00044;
      #1;
      check_eq("t6_rdy0_compare", {31'd0, rdy[0][0]}, 32'd0);
      @(negedge clk); #1;
      check_eq("t6_rdy0_respond", {31'd0, rdy[0][0]}, 32'd0);
      v[0][0] = 1'b0;
      drain("t6_drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
